// File: rtl/takvim_pkg.sv
// Calendar core shared definitions: field-select encoding, field limits, month-length helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package takvim_pkg;

    typedef enum logic [2:0] {
        ALAN_SANIYE = 3'd0,
        ALAN_DAKIKA = 3'd1,
        ALAN_SAAT   = 3'd2,
        ALAN_GUN    = 3'd3,
        ALAN_AY     = 3'd4,
        ALAN_YIL    = 3'd5,
        ALAN_YOK_6  = 3'd6,
        ALAN_YOK_7  = 3'd7
    } alan_t;

    localparam logic [5:0] SANIYE_MAX = 6'd59;
    localparam logic [5:0] DAKIKA_MAX = 6'd59;
    localparam logic [4:0] SAAT_MAX   = 5'd23;
    localparam logic [4:0] GUN_MIN    = 5'd1;
    localparam logic [3:0] AY_MIN     = 4'd1;
    localparam logic [3:0] AY_MAX     = 4'd12;

    // Gregorian rule: every 4th year, except centuries not divisible by 400.
    function automatic logic artik_yil(input int unsigned yil);
        return ((yil % 4) == 0) && (((yil % 100) != 0) || ((yil % 400) == 0));
    endfunction

    function automatic logic [4:0] ay_uzunlugu(input logic [3:0] ay, input int unsigned yil);
        logic [4:0] uzunluk;
        case (ay)
            4'd2:                    uzunluk = artik_yil(yil) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: uzunluk = 5'd30;
            default:                 uzunluk = 5'd31;
        endcase
        return uzunluk;
    endfunction

endpackage

// File: rtl/tik_uretici.sv
// Seconds-tick prescaler: counts 0..P-1 with P = max(1, CLK_HZ >> hiz_sec), restarts on speed change.
// Latency: tik is combinational from the counter state; fires in the cycle the counter holds P-1.
// Backpressure: none; counter held at 0 while calis is low.
// Ports: clk, reset (sync, active-high), calis (run enable), hiz_sec (speed exponent), tik (one-cycle pulse).
module tik_uretici
    import takvim_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int HIZ_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             calis,
    input  logic [HIZ_W-1:0] hiz_sec,
    output logic             tik
);

    // Largest count is CLK_HZ-1 (at hiz_sec = 0).
    localparam int SAYAC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic [SAYAC_W-1:0] sayac_q, sayac_d;
    logic [HIZ_W-1:0]   hiz_q, hiz_d;
    logic [31:0]        periyot;
    logic               hiz_degisti;

    always_comb begin
        periyot = 32'(CLK_HZ) >> hiz_sec;
        if (periyot == 32'd0) begin
            periyot = 32'd1;
        end
        hiz_degisti = (hiz_sec != hiz_q);
        hiz_d       = hiz_sec;
        tik         = 1'b0;
        sayac_d     = sayac_q;
        // A speed change restarts the period so the new rate starts clean.
        if (!calis || hiz_degisti) begin
            sayac_d = '0;
        end else if (32'(sayac_q) == (periyot - 32'd1)) begin
            tik     = 1'b1;
            sayac_d = '0;
        end else begin
            sayac_d = sayac_q + SAYAC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sayac_q <= '0;
            // Track the input through reset so a static setting is not seen as a change.
            hiz_q   <= hiz_sec;
        end else begin
            sayac_q <= sayac_d;
            hiz_q   <= hiz_d;
        end
    end

endmodule

// File: rtl/takvim_sayaci.sv
// Real-time calendar core: seconds cascade with true month lengths and leap years, run/stop, per-field edit.
// Latency: all outputs registered; edits and ticks appear one cycle after the causing event.
// Backpressure: none; edits while running are dropped and flagged on duzenleme_hatasi.
// Ports: CLK, reset (sync, active-high), calis_dur (toggle run), hiz_sec, alan_sec, arttir/azalt (edit pulses),
//        saniye/dakika/saat/gun/ay/yil fields, calisiyor, saniye_tik, gun_tasma, duzenleme_hatasi pulses.
module takvim_sayaci
    import takvim_pkg::*;
#(
    parameter int CLK_HZ        = 100_000_000,
    parameter int HIZ_W         = 3,
    parameter int YIL_W         = 12,
    parameter int YIL_MIN       = 2000,
    parameter int YIL_MAX       = 2099,
    parameter int BASLANGIC_YIL = 2024
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             calis_dur,
    input  logic [HIZ_W-1:0] hiz_sec,
    input  logic [2:0]       alan_sec,
    input  logic             arttir,
    input  logic             azalt,
    output logic [5:0]       saniye,
    output logic [5:0]       dakika,
    output logic [4:0]       saat,
    output logic [4:0]       gun,
    output logic [3:0]       ay,
    output logic [YIL_W-1:0] yil,
    output logic             calisiyor,
    output logic             saniye_tik,
    output logic             gun_tasma,
    output logic             duzenleme_hatasi
);

    localparam logic [YIL_W-1:0] YIL_ALT = YIL_W'(YIL_MIN);
    localparam logic [YIL_W-1:0] YIL_UST = YIL_W'(YIL_MAX);
    localparam logic [YIL_W-1:0] YIL_ILK = YIL_W'(BASLANGIC_YIL);

    logic [5:0]       saniye_q, saniye_d;
    logic [5:0]       dakika_q, dakika_d;
    logic [4:0]       saat_q, saat_d;
    logic [4:0]       gun_q, gun_d;
    logic [3:0]       ay_q, ay_d;
    logic [YIL_W-1:0] yil_q, yil_d;
    logic             calisiyor_q, calisiyor_d;
    logic             saniye_tik_q, saniye_tik_d;
    logic             gun_tasma_q, gun_tasma_d;
    logic             hata_q, hata_d;

    logic             tik;
    logic             tek_yon;
    logic [4:0]       ay_uzun;
    logic [4:0]       yeni_uzun;
    logic [3:0]       yeni_ay;
    logic [YIL_W-1:0] yeni_yil;

    tik_uretici #(
        .CLK_HZ (CLK_HZ),
        .HIZ_W  (HIZ_W)
    ) u_tik (
        .clk     (CLK),
        .reset   (reset),
        .calis   (calisiyor_q),
        .hiz_sec (hiz_sec),
        .tik     (tik)
    );

    always_comb begin
        saniye_d     = saniye_q;
        dakika_d     = dakika_q;
        saat_d       = saat_q;
        gun_d        = gun_q;
        ay_d         = ay_q;
        yil_d        = yil_q;
        saniye_tik_d = 1'b0;
        gun_tasma_d  = 1'b0;
        yeni_ay      = ay_q;
        yeni_yil     = yil_q;
        yeni_uzun    = 5'd31;

        // Toggle uses the pre-toggle state; edits below see calisiyor_q, not calisiyor_d.
        calisiyor_d  = calis_dur ? ~calisiyor_q : calisiyor_q;

        // Both pulses together is treated as no request at all.
        tek_yon      = arttir ^ azalt;
        hata_d       = calisiyor_q && tek_yon;

        ay_uzun      = ay_uzunlugu(ay_q, 32'(yil_q));

        // tik only fires while running, so it never competes with an edit.
        if (tik) begin
            saniye_tik_d = 1'b1;
            if (saniye_q >= SANIYE_MAX) begin
                saniye_d = '0;
                if (dakika_q >= DAKIKA_MAX) begin
                    dakika_d = '0;
                    if (saat_q >= SAAT_MAX) begin
                        saat_d      = '0;
                        gun_tasma_d = 1'b1;
                        if (gun_q >= ay_uzun) begin
                            gun_d = GUN_MIN;
                            if (ay_q >= AY_MAX) begin
                                ay_d  = AY_MIN;
                                yil_d = (yil_q >= YIL_UST) ? YIL_ALT : yil_q + YIL_W'(1);
                            end else begin
                                ay_d = ay_q + 4'd1;
                            end
                        end else begin
                            gun_d = gun_q + 5'd1;
                        end
                    end else begin
                        saat_d = saat_q + 5'd1;
                    end
                end else begin
                    dakika_d = dakika_q + 6'd1;
                end
            end else begin
                saniye_d = saniye_q + 6'd1;
            end
        end else if (!calisiyor_q && tek_yon) begin
            case (alan_t'(alan_sec))
                ALAN_SANIYE: begin
                    if (arttir) saniye_d = (saniye_q >= SANIYE_MAX) ? 6'd0 : saniye_q + 6'd1;
                    else        saniye_d = (saniye_q == 6'd0) ? SANIYE_MAX : saniye_q - 6'd1;
                end
                ALAN_DAKIKA: begin
                    if (arttir) dakika_d = (dakika_q >= DAKIKA_MAX) ? 6'd0 : dakika_q + 6'd1;
                    else        dakika_d = (dakika_q == 6'd0) ? DAKIKA_MAX : dakika_q - 6'd1;
                end
                ALAN_SAAT: begin
                    if (arttir) saat_d = (saat_q >= SAAT_MAX) ? 5'd0 : saat_q + 5'd1;
                    else        saat_d = (saat_q == 5'd0) ? SAAT_MAX : saat_q - 5'd1;
                end
                ALAN_GUN: begin
                    if (arttir) gun_d = (gun_q >= ay_uzun) ? GUN_MIN : gun_q + 5'd1;
                    else        gun_d = (gun_q <= GUN_MIN) ? ay_uzun : gun_q - 5'd1;
                end
                ALAN_AY: begin
                    if (arttir) yeni_ay = (ay_q >= AY_MAX) ? AY_MIN : ay_q + 4'd1;
                    else        yeni_ay = (ay_q <= AY_MIN) ? AY_MAX : ay_q - 4'd1;
                    ay_d      = yeni_ay;
                    // Keep the day valid for the month just selected.
                    yeni_uzun = ay_uzunlugu(yeni_ay, 32'(yil_q));
                    if (gun_q > yeni_uzun) gun_d = yeni_uzun;
                end
                ALAN_YIL: begin
                    if (arttir) yeni_yil = (yil_q >= YIL_UST) ? YIL_ALT : yil_q + YIL_W'(1);
                    else        yeni_yil = (yil_q <= YIL_ALT) ? YIL_UST : yil_q - YIL_W'(1);
                    yil_d     = yeni_yil;
                    // Leaving a leap year can shorten February.
                    yeni_uzun = ay_uzunlugu(ay_q, 32'(yeni_yil));
                    if (gun_q > yeni_uzun) gun_d = yeni_uzun;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            saniye_q     <= '0;
            dakika_q     <= '0;
            saat_q       <= '0;
            gun_q        <= GUN_MIN;
            ay_q         <= AY_MIN;
            yil_q        <= YIL_ILK;
            calisiyor_q  <= 1'b1;
            saniye_tik_q <= 1'b0;
            gun_tasma_q  <= 1'b0;
            hata_q       <= 1'b0;
        end else begin
            saniye_q     <= saniye_d;
            dakika_q     <= dakika_d;
            saat_q       <= saat_d;
            gun_q        <= gun_d;
            ay_q         <= ay_d;
            yil_q        <= yil_d;
            calisiyor_q  <= calisiyor_d;
            saniye_tik_q <= saniye_tik_d;
            gun_tasma_q  <= gun_tasma_d;
            hata_q       <= hata_d;
        end
    end

    assign saniye           = saniye_q;
    assign dakika           = dakika_q;
    assign saat             = saat_q;
    assign gun              = gun_q;
    assign ay               = ay_q;
    assign yil              = yil_q;
    assign calisiyor        = calisiyor_q;
    assign saniye_tik       = saniye_tik_q;
    assign gun_tasma        = gun_tasma_q;
    assign duzenleme_hatasi = hata_q;

endmodule

// File: tb/tb_takvim_sayaci.sv
// Directed bench for takvim_sayaci at CLK_HZ = 16 with hand-computed expected dates.
// Latency: n/a.
// Backpressure: n/a.
module tb_takvim_sayaci;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        calis_dur = 1'b0;
    logic [2:0]  hiz_sec = 3'd0;
    logic [2:0]  alan_sec = 3'd7;
    logic        arttir = 1'b0;
    logic        azalt = 1'b0;
    logic [5:0]  saniye, dakika;
    logic [4:0]  saat, gun;
    logic [3:0]  ay;
    logic [11:0] yil;
    logic        calisiyor, saniye_tik, gun_tasma, duzenleme_hatasi;

    int kontrol_sayisi = 0;
    int hata_sayisi    = 0;

    localparam logic [2:0] SN = 3'd0, DK = 3'd1, SA = 3'd2, GN = 3'd3, AY = 3'd4, YL = 3'd5;

    takvim_sayaci #(
        .CLK_HZ        (16),
        .HIZ_W         (3),
        .YIL_W         (12),
        .YIL_MIN       (2000),
        .YIL_MAX       (2099),
        .BASLANGIC_YIL (2024)
    ) dut (
        .CLK              (clk),
        .reset            (reset),
        .calis_dur        (calis_dur),
        .hiz_sec          (hiz_sec),
        .alan_sec         (alan_sec),
        .arttir           (arttir),
        .azalt            (azalt),
        .saniye           (saniye),
        .dakika           (dakika),
        .saat             (saat),
        .gun              (gun),
        .ay               (ay),
        .yil              (yil),
        .calisiyor        (calisiyor),
        .saniye_tik       (saniye_tik),
        .gun_tasma        (gun_tasma),
        .duzenleme_hatasi (duzenleme_hatasi)
    );

    always #5 clk = ~clk;

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        kontrol_sayisi++;
        if (gozlenen !== beklenen) begin
            hata_sayisi++;
            $display("FAIL %s: got %0d expected %0d", etiket, gozlenen, beklenen);
        end
    endtask

    // Advance n clock edges; outputs are sampled 1 time unit after each edge.
    task automatic adim(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sifirla();
        reset = 1'b1;
        adim(2);
        reset = 1'b0;
    endtask

    task automatic calis_degistir();
        calis_dur = 1'b1;
        adim(1);
        calis_dur = 1'b0;
    endtask

    task automatic duzenle(input logic [2:0] alan, input logic yukari, input int n);
        alan_sec = alan;
        for (int i = 0; i < n; i++) begin
            arttir = yukari;
            azalt  = ~yukari;
            adim(1);
        end
        arttir = 1'b0;
        azalt  = 1'b0;
    endtask

    task automatic tarih_kontrol(input string etiket, input int y, input int a, input int g,
                                 input int sa, input int dk, input int sn);
        kontrol({etiket, ".yil"},    32'(yil),    32'(y));
        kontrol({etiket, ".ay"},     32'(ay),     32'(a));
        kontrol({etiket, ".gun"},    32'(gun),    32'(g));
        kontrol({etiket, ".saat"},   32'(saat),   32'(sa));
        kontrol({etiket, ".dakika"}, 32'(dakika), 32'(dk));
        kontrol({etiket, ".saniye"}, 32'(saniye), 32'(sn));
    endtask

    task automatic sifir_durum_kontrol(input string etiket);
        tarih_kontrol(etiket, 2024, 1, 1, 0, 0, 0);
        kontrol({etiket, ".calisiyor"}, 32'(calisiyor), 32'd1);
        kontrol({etiket, ".tik"},       32'(saniye_tik), 32'd0);
        kontrol({etiket, ".tasma"},     32'(gun_tasma), 32'd0);
        kontrol({etiket, ".hata"},      32'(duzenleme_hatasi), 32'd0);
    endtask

    initial begin
        // Reset state
        adim(1);
        sifirla();
        sifir_durum_kontrol("reset");

        // 1. Basic tick: P = 16
        adim(15);
        kontrol("t1.sn_before", 32'(saniye), 32'd0);
        kontrol("t1.tik_before", 32'(saniye_tik), 32'd0);
        adim(1);
        kontrol("t1.sn_16", 32'(saniye), 32'd1);
        kontrol("t1.tik_16", 32'(saniye_tik), 32'd1);
        adim(1);
        kontrol("t1.tik_17", 32'(saniye_tik), 32'd0);
        adim(943);
        kontrol("t1.dk_960", 32'(dakika), 32'd1);
        kontrol("t1.sn_960", 32'(saniye), 32'd0);

        // 2. Leap year 2024
        sifirla();
        calis_degistir();
        kontrol("t2.stopped", 32'(calisiyor), 32'd0);
        duzenle(SN, 1'b0, 1);
        duzenle(DK, 1'b0, 1);
        duzenle(SA, 1'b0, 1);
        duzenle(AY, 1'b1, 1);
        duzenle(GN, 1'b0, 2);
        tarih_kontrol("t2.set", 2024, 2, 28, 23, 59, 59);
        calis_degistir();
        adim(15);
        kontrol("t2.sn_hold", 32'(saniye), 32'd59);
        adim(1);
        tarih_kontrol("t2.leap", 2024, 2, 29, 0, 0, 0);
        kontrol("t2.tasma", 32'(gun_tasma), 32'd1);
        kontrol("t2.tik", 32'(saniye_tik), 32'd1);

        // 2b. Non-leap 2023 (year edit clamps Feb 29 to 28)
        calis_degistir();
        duzenle(YL, 1'b0, 1);
        kontrol("t2b.clamp", 32'(gun), 32'd28);
        duzenle(SN, 1'b0, 1);
        duzenle(DK, 1'b0, 1);
        duzenle(SA, 1'b0, 1);
        tarih_kontrol("t2b.set", 2023, 2, 28, 23, 59, 59);
        calis_degistir();
        adim(16);
        tarih_kontrol("t2b.mar", 2023, 3, 1, 0, 0, 0);
        kontrol("t2b.tasma", 32'(gun_tasma), 32'd1);

        // 3. Year wrap
        calis_degistir();
        duzenle(AY, 1'b1, 9);
        duzenle(GN, 1'b0, 1);
        duzenle(YL, 1'b0, 24);
        duzenle(SN, 1'b0, 1);
        duzenle(DK, 1'b0, 1);
        duzenle(SA, 1'b0, 1);
        tarih_kontrol("t3.set", 2099, 12, 31, 23, 59, 59);
        calis_degistir();
        adim(16);
        tarih_kontrol("t3.wrap", 2000, 1, 1, 0, 0, 0);
        kontrol("t3.tik", 32'(saniye_tik), 32'd1);
        kontrol("t3.tasma", 32'(gun_tasma), 32'd1);

        // 4. Day clamp on month and year edits
        calis_degistir();
        duzenle(YL, 1'b1, 24);
        duzenle(AY, 1'b1, 2);
        duzenle(GN, 1'b0, 1);
        tarih_kontrol("t4.set", 2024, 3, 31, 0, 0, 0);
        duzenle(AY, 1'b0, 1);
        kontrol("t4.ay", 32'(ay), 32'd2);
        kontrol("t4.gun29", 32'(gun), 32'd29);
        duzenle(YL, 1'b0, 1);
        kontrol("t4.yil", 32'(yil), 32'd2023);
        kontrol("t4.gun28", 32'(gun), 32'd28);
        duzenle(3'd6, 1'b1, 1);
        tarih_kontrol("t4.alan6", 2023, 2, 28, 0, 0, 0);
        kontrol("t4.alan6_hata", 32'(duzenleme_hatasi), 32'd0);

        // 5. Edit while running
        calis_degistir();
        alan_sec = SN;
        arttir = 1'b1;
        adim(1);
        arttir = 1'b0;
        kontrol("t5.sn", 32'(saniye), 32'd0);
        kontrol("t5.hata", 32'(duzenleme_hatasi), 32'd1);
        adim(1);
        kontrol("t5.hata_off", 32'(duzenleme_hatasi), 32'd0);
        arttir = 1'b1;
        azalt  = 1'b1;
        adim(1);
        arttir = 1'b0;
        azalt  = 1'b0;
        kontrol("t5.both_hata", 32'(duzenleme_hatasi), 32'd0);
        kontrol("t5.both_sn", 32'(saniye), 32'd0);

        // 6. Speed change: P = 4, then restart at P = 16, then reset mid-period
        hiz_sec = 3'd2;
        sifirla();
        adim(3);
        kontrol("t6.sn_3", 32'(saniye), 32'd0);
        adim(1);
        kontrol("t6.sn_4", 32'(saniye), 32'd1);
        kontrol("t6.tik_4", 32'(saniye_tik), 32'd1);
        adim(4);
        kontrol("t6.sn_8", 32'(saniye), 32'd2);
        adim(2);
        hiz_sec = 3'd0;
        adim(1);
        adim(15);
        kontrol("t6.restart_hold", 32'(saniye), 32'd2);
        kontrol("t6.restart_notik", 32'(saniye_tik), 32'd0);
        adim(1);
        kontrol("t6.restart_sn", 32'(saniye), 32'd3);
        kontrol("t6.restart_tik", 32'(saniye_tik), 32'd1);
        adim(10);
        reset = 1'b1;
        adim(1);
        reset = 1'b0;
        sifir_durum_kontrol("t6.rst");
        adim(15);
        kontrol("t6.post_hold", 32'(saniye), 32'd0);
        adim(1);
        kontrol("t6.post_sn", 32'(saniye), 32'd1);

        $display("CHECKS %0d ERRORS %0d", kontrol_sayisi, hata_sayisi);
        $finish;
    end

endmodule
